teclado_matricial: RTL and testbench



---
 rtl/teclado_matricial_pkg.sv | 61 ++++++
 rtl/teclado_varredura.sv | 111 +++++++++++
 rtl/teclado_matricial.sv | 81 ++++++++
 tb/tb_teclado_matricial.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_matricial_pkg.sv
// Shared types for the keypad producer: password buffer, key codes,
// scan FSM states and the row/column to key-code map.
package teclado_matricial_pkg;

  localparam int N_DIGITS = 20;

  typedef struct packed {
    logic [N_DIGITS-1:0][3:0] digits;
  } senhaPac_t;

  localparam logic [3:0] KEY_CONFIRM = 4'hA;
  localparam logic [3:0] KEY_CLEAR   = 4'hB;
  localparam logic [3:0] KEY_TIMEOUT = 4'hE;
  localparam logic [3:0] KEY_EMPTY   = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_WAIT_RELEASE
  } teclado_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } key_map_t;

  // Column 3 holds the letters A-D, which never produce an event.
  function automatic key_map_t key_lookup(
    input logic [1:0] r,
    input logic [1:0] c
  );
    key_map_t m;
    m.valid = 1'b0;
    m.code  = KEY_EMPTY;
    if (c != 2'd3) begin
      m.valid = 1'b1;
      unique case (r)
        2'd0: m.code = 4'd1 + {2'b00, c};
        2'd1: m.code = 4'd4 + {2'b00, c};
        2'd2: m.code = 4'd7 + {2'b00, c};
        default: begin
          if (c == 2'd0)      m.code = KEY_CONFIRM;
          else if (c == 2'd1) m.code = 4'd0;
          else                m.code = KEY_CLEAR;
        end
      endcase
    end
    return m;
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] row);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/teclado_varredura.sv
// Column scanner with press/release debounce; emits one key event
// per physical press.
module teclado_varredura
  import teclado_matricial_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_key_code,
  output logic       o_key_event
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ?
                           SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  teclado_state_t   r_state;
  teclado_state_t   w_state_nx;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nx;
  logic [1:0]       r_row_idx;
  logic [1:0]       w_row_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [3:0]       r_col;
  key_map_t         w_map;

  assign w_map = key_lookup(r_row_idx, r_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_SCAN;
      r_idx     <= 2'd0;
      r_row_idx <= 2'd0;
      r_cnt     <= '0;
      r_col     <= 4'hF;
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_row_idx <= w_row_nx;
      r_cnt     <= w_cnt_nx;
      r_col     <= ~(4'b0001 << w_idx_nx);
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_row_nx   = r_row_idx;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      ST_SCAN: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt_nx = '0;
          if (i_row != 4'hF) begin
            w_state_nx = ST_DEBOUNCE;
            w_row_nx   = lowest_low(i_row);
          end else begin
            w_idx_nx = r_idx + 2'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      ST_DEBOUNCE: begin
        if (i_row[r_row_idx]) begin
          w_state_nx = ST_SCAN;
          w_cnt_nx   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_cnt_nx   = '0;
          // Disabled presses and letters are swallowed here.
          w_state_nx = (i_en && w_map.valid) ? ST_EMIT : ST_WAIT_RELEASE;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      ST_EMIT: begin
        w_state_nx = ST_WAIT_RELEASE;
        w_cnt_nx   = '0;
      end
      ST_WAIT_RELEASE: begin
        if (i_row != 4'hF) begin
          w_cnt_nx = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = ST_SCAN;
          w_idx_nx   = r_idx + 2'd1;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nx = ST_SCAN;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign o_col       = r_col;
  assign o_key_code  = w_map.code;
  assign o_key_event = (r_state == ST_EMIT);

endmodule

// File: rtl/teclado_matricial.sv
// Keypad producer: rolling 20-digit buffer, inactivity timeout and
// enable gating on top of the column scanner.
module teclado_matricial
  import teclado_matricial_pkg::*;
#(
  parameter int UM_SEGUNDO      = 1000,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int TIMEOUT_S       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       teclado_en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output senhaPac_t  digitos_value,
  output logic       digitos_valid
);

  localparam int TIMEOUT_CYCLES = TIMEOUT_S * UM_SEGUNDO;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic [3:0]       w_key_code;
  logic             w_key_event;
  logic             w_timeout;
  logic             w_busy;
  senhaPac_t        r_digits;
  logic             r_valid;
  logic             r_clear;
  logic [TMR_W-1:0] r_timer;

  teclado_varredura #(
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_varredura (
    .clk        (clk),
    .rst        (rst),
    .i_en       (teclado_en),
    .i_row      (row),
    .o_col      (col),
    .o_key_code (w_key_code),
    .o_key_event(w_key_event)
  );

  assign w_busy    = (r_digits.digits[0] != KEY_EMPTY);
  assign w_timeout = w_busy && (r_timer == TMR_LAST);

  // Key beats a coincident timeout; confirm/clear/timeout wipe next cycle.
  always_ff @(posedge clk) begin
    if (rst || !teclado_en) begin
      r_digits <= '1;
      r_valid  <= 1'b0;
      r_clear  <= 1'b0;
      r_timer  <= '0;
    end else if (w_key_event) begin
      r_digits.digits <= {r_digits.digits[N_DIGITS-2:0], w_key_code};
      r_valid <= 1'b1;
      r_clear <= (w_key_code == KEY_CONFIRM) || (w_key_code == KEY_CLEAR);
      r_timer <= '0;
    end else if (r_clear) begin
      r_digits <= '1;
      r_valid  <= 1'b0;
      r_clear  <= 1'b0;
      r_timer  <= '0;
    end else if (w_timeout) begin
      r_digits.digits <= {N_DIGITS{KEY_TIMEOUT}};
      r_valid <= 1'b1;
      r_clear <= 1'b1;
      r_timer <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_busy) r_timer <= r_timer + TMR_ONE;
    end
  end

  assign digitos_value = r_digits;
  assign digitos_valid = r_valid;

endmodule

// File: tb/tb_teclado_matricial.sv
// Bench for teclado_matricial: keypad matrix model plus a scoreboard
// of expected buffer snapshots checked on every strobe.
module tb_teclado_matricial;
  import teclado_matricial_pkg::*;

  localparam int UM_SEGUNDO = 1000;
  localparam int SETTLE     = 4;
  localparam int DEB        = 20;
  localparam int TIMEOUT_S  = 5;
  localparam int TMO        = TIMEOUT_S * UM_SEGUNDO;

  logic       clk = 1'b0;
  logic       rst;
  logic       teclado_en;
  logic [3:0] row;
  logic [3:0] col;
  senhaPac_t  digitos_value;
  logic       digitos_valid;

  logic       contact;
  logic [1:0] kr;
  logic [1:0] kc;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int n_strobes   = 0;
  int strobe_cyc  = 0;

  senhaPac_t exp_q[$];
  senhaPac_t model;
  senhaPac_t exp_v;
  senhaPac_t last_val;
  senhaPac_t post_val;
  senhaPac_t all_f;
  senhaPac_t all_e;
  logic      post_valid = 1'b0;
  bit        prev_strobe = 1'b0;

  teclado_matricial #(
    .UM_SEGUNDO     (UM_SEGUNDO),
    .SETTLE_CYCLES  (SETTLE),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_S      (TIMEOUT_S)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .teclado_en   (teclado_en),
    .row          (row),
    .col          (col),
    .digitos_value(digitos_value),
    .digitos_valid(digitos_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row = 4'hF;
    if (contact && !col[kc]) row[kr] = 1'b0;
  end

  always @(negedge clk) begin
    if (prev_strobe) begin
      post_val   = digitos_value;
      post_valid = digitos_valid;
    end
    prev_strobe = 1'b0;
    if (!rst && digitos_valid) begin
      n_strobes++;
      strobe_cyc  = cyc;
      last_val    = digitos_value;
      prev_strobe = 1'b1;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got %h, required no strobe",
                 digitos_value);
      end else begin
        exp_v = exp_q.pop_front();
        if (digitos_value !== exp_v) begin
          miscompares++;
          $display("FAIL strobe_value: got %h, required %h",
                   digitos_value, exp_v);
        end
      end
    end
  end

  task automatic key_pos(input logic [3:0] code,
                         output logic [1:0] r, output logic [1:0] c);
    case (code)
      4'h1: begin r = 2'd0; c = 2'd0; end
      4'h2: begin r = 2'd0; c = 2'd1; end
      4'h3: begin r = 2'd0; c = 2'd2; end
      4'h4: begin r = 2'd1; c = 2'd0; end
      4'h5: begin r = 2'd1; c = 2'd1; end
      4'h6: begin r = 2'd1; c = 2'd2; end
      4'h7: begin r = 2'd2; c = 2'd0; end
      4'h8: begin r = 2'd2; c = 2'd1; end
      4'h9: begin r = 2'd2; c = 2'd2; end
      4'hA: begin r = 2'd3; c = 2'd0; end
      4'h0: begin r = 2'd3; c = 2'd1; end
      4'hB: begin r = 2'd3; c = 2'd2; end
      default: begin r = 2'd0; c = 2'd3; end
    endcase
  endtask

  task automatic press_rc(input logic [1:0] r, input logic [1:0] c,
                          input int hold);
    kr = r;
    kc = c;
    contact = 1'b1;
    repeat (hold) @(negedge clk);
    contact = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic push_key(input logic [3:0] code);
    model.digits = {model.digits[18:0], code};
    exp_q.push_back(model);
    if (code == KEY_CONFIRM || code == KEY_CLEAR) model = all_f;
  endtask

  task automatic press_key(input logic [3:0] code);
    logic [1:0] r;
    logic [1:0] c;
    key_pos(code, r, c);
    push_key(code);
    press_rc(r, c, 60);
  endtask

  task automatic wait_strobe(input int n0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_strobes != n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic disable_clear();
    teclado_en = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (digitos_value !== all_f || digitos_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_off_clear: got %h/%b, required %h/0",
               digitos_value, digitos_valid, all_f);
    end
    teclado_en = 1'b1;
    model = all_f;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] seen;
    int bad;
    rst = 1'b1;
    teclado_en = 1'b1;
    contact = 1'b0;
    kr = 2'd0;
    kc = 2'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if (col !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_col: got %h, required f", col);
    end
    vectors++;
    if (digitos_value !== all_f) begin
      miscompares++;
      $display("FAIL reset_value: got %h, required %h", digitos_value, all_f);
    end
    vectors++;
    if (digitos_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b, required 0", digitos_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (col !== 4'hE) begin
      miscompares++;
      $display("FAIL first_col: got %h, required e", col);
    end
    seen = 4'h0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!(col inside {4'hE, 4'hD, 4'hB, 4'h7})) bad++;
      seen |= ~col;
    end
    vectors++;
    if (bad != 0 || seen !== 4'hF) begin
      miscompares++;
      $display("FAIL scan_cols: got bad=%0d seen=%h, required 0/f",
               bad, seen);
    end
  endtask

  task automatic test_three_keys();
    senhaPac_t e;
    int n0;
    n0 = n_strobes;
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    e = all_f;
    e.digits[2] = 4'h1;
    e.digits[1] = 4'h2;
    e.digits[0] = 4'h3;
    vectors++;
    if (n_strobes != n0 + 3) begin
      miscompares++;
      $display("FAIL three_count: got %0d, required 3", n_strobes - n0);
    end
    vectors++;
    if (digitos_value !== e || post_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL three_value: got %h/%b, required %h/0",
               digitos_value, post_valid, e);
    end
    disable_clear();
  endtask

  task automatic test_letter();
    int n0;
    n0 = n_strobes;
    press_rc(2'd1, 2'd3, 60);
    vectors++;
    if (n_strobes != n0 || digitos_value !== all_f) begin
      miscompares++;
      $display("FAIL letter_b: got %0d strobes %h, required 0 %h",
               n_strobes - n0, digitos_value, all_f);
    end
  endtask

  task automatic test_latency();
    int c0;
    int n0;
    bit ok;
    kr = 2'd1;
    kc = 2'd1;
    contact = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (col == 4'b1101) break;
    end
    for (int i = 0; i < 64; i++) begin
      if (col != 4'b1101) break;
      @(negedge clk);
    end
    push_key(4'h5);
    n0 = n_strobes;
    contact = 1'b1;
    c0 = -1000;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (col == 4'b1101) begin
        c0 = cyc;
        break;
      end
    end
    wait_strobe(n0, 100, ok);
    vectors++;
    if (!ok || strobe_cyc != c0 + SETTLE + DEB + 1) begin
      miscompares++;
      $display("FAIL latency: got %0d, required %0d (ok=%0d)",
               strobe_cyc - c0, SETTLE + DEB + 1, ok);
    end
    @(negedge clk);
    contact = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_chatter();
    int n0;
    int last_edge;
    kr = 2'd2;
    kc = 2'd1;
    contact = 1'b0;
    push_key(4'h8);
    n0 = n_strobes;
    last_edge = 0;
    for (int i = 0; i < 5; i++) begin
      contact = ~contact;
      last_edge = cyc + 1;
      repeat (3) @(negedge clk);
    end
    repeat (57) @(negedge clk);
    contact = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (n_strobes != n0 + 1) begin
      miscompares++;
      $display("FAIL chatter_count: got %0d, required 1", n_strobes - n0);
    end
    vectors++;
    if (strobe_cyc - last_edge < DEB + 1 ||
        strobe_cyc - last_edge > DEB + 1 + 4 * SETTLE) begin
      miscompares++;
      $display("FAIL chatter_latency: got %0d, required %0d..%0d",
               strobe_cyc - last_edge, DEB + 1, DEB + 1 + 4 * SETTLE);
    end
  endtask

  task automatic test_clear();
    for (int d = 1; d <= 5; d++) press_key(4'(d));
    press_key(KEY_CLEAR);
    vectors++;
    if (last_val.digits[0] !== KEY_CLEAR) begin
      miscompares++;
      $display("FAIL clear_code: got %h, required b", last_val.digits[0]);
    end
    vectors++;
    if (post_val !== all_f || post_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_after: got %h/%b, required %h/0",
               post_val, post_valid, all_f);
    end
  endtask

  task automatic test_rolling();
    senhaPac_t e;
    for (int j = 0; j < 22; j++) press_key(4'(j % 10));
    press_key(KEY_CONFIRM);
    e.digits[0] = KEY_CONFIRM;
    for (int i = 1; i < 20; i++) e.digits[i] = 4'((22 - i) % 10);
    vectors++;
    if (last_val !== e) begin
      miscompares++;
      $display("FAIL rolling: got %h, required %h", last_val, e);
    end
    vectors++;
    if (post_val !== all_f) begin
      miscompares++;
      $display("FAIL confirm_after: got %h, required %h", post_val, all_f);
    end
  endtask

  task automatic test_enable();
    int n0;
    n0 = n_strobes;
    teclado_en = 1'b0;
    kr = 2'd2;
    kc = 2'd0;
    contact = 1'b1;
    repeat (60) @(negedge clk);
    vectors++;
    if (n_strobes != n0 || digitos_value !== all_f) begin
      miscompares++;
      $display("FAIL en_off_press: got %0d strobes %h, required 0 %h",
               n_strobes - n0, digitos_value, all_f);
    end
    teclado_en = 1'b1;
    repeat (60) @(negedge clk);
    contact = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (n_strobes != n0) begin
      miscompares++;
      $display("FAIL en_held_key: got %0d strobes, required 0",
               n_strobes - n0);
    end
    press_key(4'h7);
    vectors++;
    if (n_strobes != n0 + 1 || last_val.digits[0] !== 4'h7) begin
      miscompares++;
      $display("FAIL en_repress: got %0d strobes code %h, required 1 7",
               n_strobes - n0, last_val.digits[0]);
    end
    disable_clear();
  endtask

  task automatic test_timeout();
    int k;
    int n0;
    bit ok;
    press_key(4'h4);
    k = strobe_cyc;
    exp_q.push_back(all_e);
    model = all_f;
    wait_strobe(n_strobes, TMO + 200, ok);
    vectors++;
    if (!ok || strobe_cyc - k != TMO) begin
      miscompares++;
      $display("FAIL timeout_time: got %0d, required %0d (ok=%0d)",
               strobe_cyc - k, TMO, ok);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (post_val !== all_f || post_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_after: got %h/%b, required %h/0",
               post_val, post_valid, all_f);
    end
    press_key(4'h4);
    k = strobe_cyc;
    for (int i = 0; i < TMO; i++) begin
      if (cyc >= k + TMO - 50) break;
      @(negedge clk);
    end
    n0 = n_strobes;
    press_key(4'h5);
    vectors++;
    if (n_strobes != n0 + 1 || strobe_cyc - k >= TMO) begin
      miscompares++;
      $display("FAIL late_key: got %0d strobes at %0d, required 1 before %0d",
               n_strobes - n0, strobe_cyc - k, TMO);
    end
    k = strobe_cyc;
    exp_q.push_back(all_e);
    model = all_f;
    wait_strobe(n_strobes, TMO + 200, ok);
    vectors++;
    if (!ok || strobe_cyc - k != TMO) begin
      miscompares++;
      $display("FAIL timer_restart: got %0d, required %0d (ok=%0d)",
               strobe_cyc - k, TMO, ok);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    all_f = '1;
    all_e.digits = {20{KEY_TIMEOUT}};
    model = '1;
    post_val = '1;
    last_val = '1;
    test_reset();
    test_three_keys();
    test_letter();
    test_latency();
    test_chatter();
    test_clear();
    test_rolling();
    test_enable();
    test_timeout();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_strobes: got %0d pending, required 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
